// File: rtl/lut_loader_pkg.sv
// Shared constants and state encoding for the serial LUT loader.
package lut_loader_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_IDX_W = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_ROT   = 2'd2;

  function automatic int unsigned bit_cnt_w(input int unsigned table_bits);
    return (table_bits > 1) ? $clog2(table_bits) : 1;
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// Byte load/shift register emitting its MSB; bit_idx counts 7 down to 0.
module byte_serializer
  import lut_loader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic [BYTE_W-1:0]    data,
  output logic                 bit_out,
  output logic [BIT_IDX_W-1:0] bit_idx,
  output logic                 last_bit
);

  logic [BYTE_W-1:0] sreg;

  // MSB of sreg is the bit currently on the wire; it holds when neither load nor shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      bit_idx <= '0;
    end else if (load) begin
      sreg    <= data;
      bit_idx <= BIT_IDX_W'(BYTE_W - 1);
    end else if (shift) begin
      sreg    <= {sreg[BYTE_W-2:0], 1'b0};
      bit_idx <= bit_idx - BIT_IDX_W'(1);
    end
  end

  assign bit_out  = sreg[BYTE_W-1];
  assign last_bit = (bit_idx == '0);

endmodule

// File: rtl/lut_serial_loader.sv
// Feeds table bytes MSB-first into a serial-load LUT and issues counted rotate bursts.
// Optional LUT_LOADER_PARITY_EN adds a running XOR of all shifted bits on load_parity.
module lut_serial_loader
  import lut_loader_pkg::*;
#(
  parameter int unsigned TABLE_BITS = 32,
  parameter int unsigned ROT_LEN    = 8,
  parameter int unsigned STEP_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  input  logic              rot_valid,
  input  logic [STEP_W-1:0] rot_steps,
  output logic              rot_ready,
  output logic              sr_d,
  output logic              sr_cs_n,
  output logic              sr_rot_n,
  output logic              busy,
  output logic              table_full,
  input  logic              clr,
  output logic              load_parity
);

  localparam int unsigned BIT_CNT_W = bit_cnt_w(TABLE_BITS);
  localparam logic [BIT_CNT_W-1:0] CNT_MAX = BIT_CNT_W'(TABLE_BITS - 1);

  if ((TABLE_BITS % BYTE_W) != 0 ||
      ((ROT_LEN == 0) ? 1'b1 : ((TABLE_BITS % ROT_LEN) != 0))) begin : g_bad_cfg
    $error("lut_serial_loader: TABLE_BITS must be a multiple of 8 and of ROT_LEN");
  end

  logic [1:0]           state, state_d;
  logic [STEP_W-1:0]    rot_cnt, rot_cnt_d;
  logic                 load, shift, last_bit, wr_ready_d;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 shifted;

  byte_serializer u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .data     (wr_data),
    .bit_out  (sr_d),
    .bit_idx  (bit_idx),
    .last_bit (last_bit)
  );

  // Next-state: a pending byte always beats a rotate request in IDLE
  always_comb begin
    state_d   = state;
    rot_cnt_d = rot_cnt;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_valid) begin
          load    = 1'b1;
          state_d = ST_SHIFT;
        end else if (rot_valid && (rot_steps != '0)) begin
          state_d   = ST_ROT;
          rot_cnt_d = rot_steps - STEP_W'(1);
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          if (wr_valid) load = 1'b1;
          else          state_d = ST_IDLE;
        end else begin
          shift = 1'b1;
        end
      end
      ST_ROT: begin
        if (rot_cnt == '0) state_d = ST_IDLE;
        else               rot_cnt_d = rot_cnt - STEP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    wr_ready_d = (state_d == ST_IDLE) ||
                 ((state_d == ST_SHIFT) && shift && (bit_idx == BIT_IDX_W'(1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rot_cnt  <= '0;
      sr_cs_n  <= 1'b1;
      sr_rot_n <= 1'b1;
      busy     <= 1'b0;
      wr_ready <= 1'b1;
    end else begin
      state    <= state_d;
      rot_cnt  <= rot_cnt_d;
      sr_cs_n  <= (state_d != ST_SHIFT);
      sr_rot_n <= (state_d != ST_ROT);
      busy     <= (state_d != ST_IDLE);
      wr_ready <= wr_ready_d;
    end
  end

  assign rot_ready = (state == ST_IDLE) && !wr_valid;

  // A bit counts at the edge where the LUT consumes it (sr_cs_n low)
  assign shifted = !sr_cs_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      table_full <= 1'b0;
    end else if (clr) begin
      bit_cnt    <= shifted ? BIT_CNT_W'(1) : '0;
      table_full <= 1'b0;
    end else if (shifted) begin
      if (bit_cnt == CNT_MAX) begin
        bit_cnt    <= '0;
        table_full <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
    end
  end

`ifdef LUT_LOADER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       load_parity <= 1'b0;
    else if (clr)     load_parity <= shifted & sr_d;
    else if (shifted) load_parity <= load_parity ^ sr_d;
  end
`else
  assign load_parity = 1'b0;
`endif

endmodule

// File: tb/tb_lut_serial_loader.sv
// Bench for lut_serial_loader with a behavioural 4x8 serial-load LUT and a bit scoreboard.
module tb_lut_serial_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, rot_valid, clr;
  logic [7:0] wr_data;
  logic [3:0] rot_steps;
  logic       wr_ready, rot_ready, sr_d, sr_cs_n, sr_rot_n, busy, table_full, load_parity;

`ifdef LUT_LOADER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, cur_run = 0, max_run = 0, last_cs = 0, first_rot = -1, rot_low = 0;
  logic [31:0] lut = '0;
  logic        exp_q[$];

  lut_serial_loader #(.TABLE_BITS(32), .ROT_LEN(8), .STEP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rot_valid(rot_valid), .rot_steps(rot_steps), .rot_ready(rot_ready), .sr_d(sr_d),
    .sr_cs_n(sr_cs_n), .sr_rot_n(sr_rot_n), .busy(busy), .table_full(table_full),
    .clr(clr), .load_parity(load_parity)
  );

  always #5 clk = ~clk;

  // LUT model and scoreboard: what is on the pins at negedge is consumed at the next posedge
  always @(negedge clk) begin
    logic e;
    if (rst_n) begin
      cyc++;
      if (!sr_cs_n && !sr_rot_n) begin
        n_tests++; n_fail++;
        $display("FAIL cs_rot_overlap cyc=%0d cs_n=0 rot_n=0 required not both low", cyc);
      end
      if (!sr_cs_n) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_shift cyc=%0d sr_d=%0b required no shift", cyc, sr_d);
        end else begin
          e = exp_q.pop_front();
          if (sr_d !== e) begin
            n_fail++;
            $display("FAIL sr_d_bit cyc=%0d got %0b required %0b", cyc, sr_d, e);
          end
        end
        lut = {lut[30:0], sr_d};
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        last_cs = cyc;
      end else begin
        cur_run = 0;
      end
      if (!sr_rot_n) begin
        rot_low++;
        if (first_rot < 0) first_rot = cyc;
        lut = {lut[7:0], lut[31:8]};
      end
    end
  end

  function automatic logic [7:0] lut_sel(input int s);
    return lut[s*8 +: 8];
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  // Offer one byte and return just after the edge that accepts it
  task automatic drive_byte(input logic [7:0] b);
    bit ok = 1'b0;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = b;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (wr_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wr_accept_timeout data=%02h wr_ready=%0b required 1", b, wr_ready);
    end else begin
      push_byte(b);
    end
    @(posedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (!busy) return;
    end
    n_tests++; n_fail++;
    $display("FAIL idle_timeout busy=%0b required 0", busy);
  endtask

  task automatic finish_write();
    @(negedge clk);
    wr_valid = 1'b0;
    wait_idle();
  endtask

  task automatic do_rot(input logic [3:0] steps);
    bit ok = 1'b0;
    @(negedge clk);
    rot_valid = 1'b1;
    rot_steps = steps;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (rot_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL rot_accept_timeout rot_ready=%0b required 1", rot_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rot_valid = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got %0b required %0b", name, got, req);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got %02h required %02h", name, got, req);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 1'b0; rot_valid = 1'b0; clr = 1'b0;
    wr_data = '0; rot_steps = '0;
    #22;
    check_bit("rst_sr_d", sr_d, 1'b0);
    check_bit("rst_cs_n", sr_cs_n, 1'b1);
    check_bit("rst_rot_n", sr_rot_n, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_table_full", table_full, 1'b0);
    check_bit("rst_parity", load_parity, 1'b0);
    @(negedge clk); rst_n = 1'b1; #1;
    check_bit("idle_wr_ready", wr_ready, 1'b1);
    check_bit("idle_rot_ready", rot_ready, 1'b1);
  endtask

  task automatic test_load();
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    max_run = 0;
    foreach (bytes[i]) drive_byte(bytes[i]);
    finish_write();
    check_int("load_contiguous_cs_cycles", max_run, 32);
    check_int("load_scoreboard_left", exp_q.size(), 0);
    check_bit("load_table_full", table_full, 1'b1);
    for (int s = 0; s < 4; s++) check_byte($sformatf("load_sel%0d", s), lut_sel(s), bytes[3-s]);
  endtask

  task automatic test_rotate();
    rot_low = 0;
    do_rot(4'd1);
    wait_idle();
    check_int("rot1_low_cycles", rot_low, 1);
    check_byte("rot1_sel0", lut_sel(0), 8'h33);
    check_byte("rot1_sel3", lut_sel(3), 8'h44);
  endtask

  task automatic test_rot_zero();
    rot_low = 0;
    @(negedge clk);
    rot_valid = 1'b1; rot_steps = 4'd0;
    #1;
    check_bit("rot0_ready", rot_ready, 1'b1);
    @(posedge clk); #1;
    check_bit("rot0_busy_after_accept", busy, 1'b0);
    @(negedge clk); rot_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_bit("rot0_busy", busy, 1'b0);
    check_int("rot0_low_cycles", rot_low, 0);
  endtask

  task automatic test_back_to_back();
    bit ok = 1'b0;
    rot_low = 0; first_rot = -1;
    @(negedge clk);
    wr_valid = 1'b1; wr_data = 8'h5A; rot_valid = 1'b1; rot_steps = 4'd2;
    #1;
    check_bit("both_rot_ready", rot_ready, 1'b0);
    check_bit("both_wr_ready", wr_ready, 1'b1);
    push_byte(8'h5A);
    @(posedge clk);
    @(negedge clk); wr_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rot_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL both_rot_timeout rot_ready=%0b required 1", rot_ready);
    end
    @(posedge clk);
    @(negedge clk); rot_valid = 1'b0;
    wait_idle();
    check_int("both_scoreboard_left", exp_q.size(), 0);
    check_int("both_rot_low_cycles", rot_low, 2);
    check_int("both_rot_start_gap", first_rot - last_cs, 2);
  endtask

  task automatic test_reset_mid();
    drive_byte(8'hA5);
    wr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("midrst_cs_n", sr_cs_n, 1'b1);
    check_bit("midrst_sr_d", sr_d, 1'b0);
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_table_full", table_full, 1'b0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_parity_counter();
    drive_byte(8'h01);
    drive_byte(8'h03);
    finish_write();
    check_bit("par_after_01_03", load_parity, PAR_EN);
    check_bit("cnt16_not_full", table_full, 1'b0);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0; #1;
    check_bit("par_after_clr", load_parity, 1'b0);
    // clr lands on the first bit of 0x80, so that bit is counted as bit 1
    drive_byte(8'h80);
    #2; clr = 1'b1; wr_valid = 1'b0;
    @(posedge clk); #1; clr = 1'b0;
    wait_idle();
    drive_byte(8'h00);
    drive_byte(8'h00);
    finish_write();
    check_bit("cnt24_not_full", table_full, 1'b0);
    check_bit("par_clr_on_bit", load_parity, PAR_EN);
    drive_byte(8'h00);
    finish_write();
    check_bit("cnt32_full", table_full, 1'b1);
    check_int("par_scoreboard_left", exp_q.size(), 0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_rotate();
    test_rot_zero();
    test_back_to_back();
    test_reset_mid();
    test_parity_counter();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
